// File: rtl/hdec_mask_pipe.sv
// Pipelined mask decoder: turns an index into a low/high thermometer, one-hot or
// range mask with saturation and popcount, behind a LAT-deep valid/ready pipeline.
module hdec_mask_pipe #(
  parameter int N   = 5,
  parameter int W   = 2**N,
  parameter int LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_mode,
  input  logic [N-1:0]             in_x,
  input  logic [N-1:0]             in_x_hi,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_y,
  output logic [$clog2(W+1)-1:0]   out_ones,
  output logic                     out_sat
);

  localparam int OW = $clog2(W+1);
  // One extra bit so that W itself (possibly 2**N) is representable in compares.
  localparam int XW = N + 1;
  localparam logic [XW-1:0] W_X = XW'(W);

  typedef enum logic [1:0] {
    MODE_LOW    = 2'd0,
    MODE_HIGH   = 2'd1,
    MODE_ONEHOT = 2'd2,
    MODE_RANGE  = 2'd3
  } mode_e;

  typedef struct packed {
    logic [W-1:0]  y;
    logic [OW-1:0] ones;
    logic          sat;
  } res_t;

  mode_e         mode;
  logic [XW-1:0] x_e;
  logic [XW-1:0] xh_e;
  logic [XW-1:0] xs;
  logic [XW-1:0] hi;
  res_t          dec;

  // ---------------------------------------------------------------------------
  // Combinational decode of the input transaction
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missed branch would otherwise infer a latch.
    dec  = '0;
    mode = mode_e'(in_mode);
    x_e  = {1'b0, in_x};
    xh_e = {1'b0, in_x_hi};
    xs   = (x_e  > W_X) ? W_X : x_e;
    hi   = (xh_e > W_X) ? W_X : xh_e;

    case (mode)
      MODE_LOW: begin
        for (int j = 0; j < W; j++) dec.y[j] = (XW'(j) < xs);
        dec.ones = OW'(xs);
        dec.sat  = (x_e > W_X);
      end
      MODE_HIGH: begin
        for (int j = 0; j < W; j++) dec.y[j] = (XW'(j) >= (W_X - xs));
        dec.ones = OW'(xs);
        dec.sat  = (x_e > W_X);
      end
      MODE_ONEHOT: begin
        for (int j = 0; j < W; j++) dec.y[j] = (XW'(j) == x_e);
        dec.ones = OW'(x_e < W_X);
        dec.sat  = (x_e >= W_X);
      end
      MODE_RANGE: begin
        // An empty or inverted range yields zero; it is not a saturation.
        for (int j = 0; j < W; j++) dec.y[j] = (XW'(j) >= xs) && (XW'(j) < hi);
        dec.ones = (hi > xs) ? OW'(hi - xs) : '0;
        dec.sat  = (x_e > W_X) || (xh_e > W_X);
      end
      default: dec = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline stages with per-stage valid and backpressure
  // ---------------------------------------------------------------------------
  logic [LAT-1:0] v_q;
  logic [LAT-1:0] v_d;
  res_t           data_q [LAT];
  res_t           data_d [LAT];
  logic [LAT-1:0] rdy;

  // A stage can take a new item if it, or any stage after it, has a hole,
  // or the sink is draining the last stage.
  always_comb begin
    logic tail_full;
    rdy = '0;
    for (int k = 0; k < LAT; k++) begin
      tail_full = 1'b1;
      for (int m = k; m < LAT; m++) tail_full = tail_full & v_q[m];
      rdy[k] = out_ready | ~tail_full;
    end
  end

  assign in_ready = rst_n & rdy[0];

  always_comb begin
    v_d = v_q;
    for (int k = 0; k < LAT; k++) data_d[k] = data_q[k];

    if (rdy[0]) begin
      v_d[0] = in_valid;
      if (in_valid) data_d[0] = dec;
    end

    for (int k = 1; k < LAT; k++) begin
      if (rdy[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) data_d[k] = data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      // NOTE: the payload registers are reset too, not just the valids, because
      // the last stage drives out_y/out_ones/out_sat which must read 0 in reset.
      data_q <= '{default: '0};
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every stage
      // samples the pre-edge value of its predecessor.
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign out_valid = v_q[LAT-1];
  assign out_y     = data_q[LAT-1].y;
  assign out_ones  = data_q[LAT-1].ones;
  assign out_sat   = data_q[LAT-1].sat;

endmodule

// File: doc/hdec_mask_pipe.md
Name: hdec_mask_pipe

Overview:
- Parametrised, pipelined successor to the combinational half-decoder.
- Turns a binary index into a W-bit mask: low thermometer, high thermometer, one-hot, or range mask.
- Carries a valid/ready handshake with backpressure, out-of-range saturation and a population-count side output.
- Feeds FPU shifter mask and sticky-bit generation, where the decode is registered to meet timing.

Parameters:
- N, 5, index width in bits.
- W, 2**N, output mask width; legal range 2 ≤ W ≤ 2**N.
- LAT, 2, pipeline depth in register stages; legal range 1..4; equals latency and capacity.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts the input this cycle.
- in_mode  in  2  0=LOW, 1=HIGH, 2=ONEHOT, 3=RANGE.
- in_x  in  N  index; lower bound in RANGE mode.
- in_x_hi  in  N  upper bound (exclusive); used only in RANGE mode.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_y  out  W  mask.
- out_ones  out  $clog2(W+1)  number of set bits in out_y.
- out_sat  out  1  an index exceeded the representable range.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits clear; out_valid=0, out_y=0, out_ones=0, out_sat=0.
  - in_ready is forced 0 while rst_n is low.
  - In-flight items are discarded; nothing is emitted after release.
- Decode is combinational on the input and captured into stage 1; stages 2..LAT carry the result unchanged.
- Per-mode result, with j = 0..W-1 and xs = min(in_x, W):
  - LOW: y[j]=1 iff j < xs. Matches the legacy half-decoder for W=2**N.
  - HIGH: y[j]=1 iff j ≥ W−xs.
  - ONEHOT: y[j]=1 iff j == in_x. If in_x ≥ W, y=0.
  - RANGE: lo=min(in_x,W), hi=min(in_x_hi,W); y[j]=1 iff lo ≤ j < hi. If hi ≤ lo, y=0.
- out_sat:
  - LOW/HIGH: set when in_x > W.
  - ONEHOT: set when in_x ≥ W.
  - RANGE: set when in_x > W or in_x_hi > W.
  - hi ≤ lo alone is not saturation.
- out_ones:
  - Equals the popcount of out_y.
  - Computed arithmetically, not by a popcount tree: LOW/HIGH → xs; ONEHOT → (in_x<W); RANGE → hi−lo or 0.
  - Registered alongside y.
- Handshake:
  - Stage k (1..LAT) holds one item with valid v_k.
  - ready_k = !v_k | ready_{k+1}, with ready_{LAT+1} = out_ready.
  - in_ready = ready_1 (combinational through the chain when rst_n is high).
  - An input is accepted on an edge with in_valid & in_ready.
  - An output is consumed on an edge with out_valid & out_ready.
  - out_valid = v_LAT; out_y, out_ones and out_sat are the stage-LAT registers.
- Timing and ordering:
  - Latency is exactly LAT cycles with no stall: accepted at edge t, visible after edge t+LAT−1.
  - Throughput is one item per cycle with out_ready held high.
  - Capacity is LAT items; with out_ready low, in_ready deasserts once all stages are valid.
  - Order is preserved; no drops or duplicates.
- Stability: while out_valid=1 and out_ready=0, out_y, out_ones and out_sat hold stable.
- Simultaneous events:
  - A full pipeline with out_ready=1 accepts a new input in the same cycle as it emits.
  - in_valid with in_ready=0 has no effect; the source must hold its data.
- in_x_hi is ignored outside RANGE mode; out_sat does not depend on it there.
- All arithmetic is unsigned; comparisons use N+1 bits so that W=2**N compares correctly.

Test Plan:
- All tests use N=5, W=24, LAT=2.
1. LOW, in_x=5, out_ready=1 → after 2 cycles: out_y=0x00001F, out_ones=5, out_sat=0. LOW, in_x=0 → out_y=0, out_ones=0.
2. HIGH, in_x=3 → out_y=0xE00000, out_ones=3. LOW, in_x=30 → out_y=0xFFFFFF, out_ones=24, out_sat=1.
3. ONEHOT, in_x=23 → out_y=0x800000, out_ones=1. ONEHOT, in_x=24 → out_y=0, out_ones=0, out_sat=1.
4. RANGE, in_x=4, in_x_hi=8 → out_y=0x0000F0, out_ones=4. in_x=8, in_x_hi=4 → out_y=0, out_sat=0. in_x=20, in_x_hi=31 → out_y=0xF00000, out_ones=4, out_sat=1.
5. Backpressure: hold out_ready=0 and push LOW 1, 2, 3 back-to-back.
   - in_ready drops after 2 accepts; item 3 is held at the input.
   - Outputs stay stable.
   - Raising out_ready yields ones = 1, 2, 3 in consecutive cycles, with no gaps once flowing.
6. Reset mid-operation: 2 items in flight, pulse rst_n low between edges.
   - out_valid, out_y and in_ready go 0 immediately.
   - After release, no stale item appears; a new LOW in_x=7 returns 0x00007F after 2 cycles.
